// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types and constants for the five-stage pipeline.
//   word_t        : one machine word (data / address bus)
//   memstate_t    : memory-stage handshake state
//   WORDADDR_LSB  : lowest address bit that selects a word (byte offset below)
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int WORDADDR_LSB = 2;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memstate_t;

endpackage

// File: rtl/link_reg.sv
// ---------------------------------------------------------------------------
// link_reg
// LL/SC link register. Holds the word address of the last load-linked and
// a valid bit. Any of an SC completion, a plain store to the linked word or
// a coherence snoop to the linked word breaks the link.
// Ports:
//   CLK, nRST          : clock, async active-low reset
//   set_en / set_word  : LL completed, link this word
//   clr_en             : SC completed, drop the link
//   wr_en / wr_word    : plain store completed to this word
//   snoop_en/snoop_word: coherence invalidation strobe and word
//   chk_word           : word an SC wants to commit to
//   link_valid         : link currently held
//   sc_ok              : SC to chk_word would succeed
// ---------------------------------------------------------------------------
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           set_en,
  input  logic [WORD_W-1:WORDADDR_LSB]   set_word,
  input  logic                           clr_en,
  input  logic                           wr_en,
  input  logic [WORD_W-1:WORDADDR_LSB]   wr_word,
  input  logic                           snoop_en,
  input  logic [WORD_W-1:WORDADDR_LSB]   snoop_word,
  input  logic [WORD_W-1:WORDADDR_LSB]   chk_word,
  output logic                           link_valid,
  output logic                           sc_ok
);

  logic [WORD_W-1:WORDADDR_LSB] link_word;
  logic                         snoop_hit_cur;
  logic                         snoop_hit_new;
  logic                         store_hit;

  // A snoop racing an LL completion is checked against the word being
  // linked, so the invalidate wins even when the old link was elsewhere.
  assign snoop_hit_cur = snoop_en && (snoop_word == link_word);
  assign snoop_hit_new = snoop_en && (snoop_word == set_word);
  assign store_hit     = wr_en && (wr_word == link_word);

  assign sc_ok = link_valid && (link_word == chk_word);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_word  <= '0;
    end else if (set_en) begin
      link_valid <= !snoop_hit_new;
      link_word  <= set_word;
    end else if (clr_en || snoop_hit_cur || store_hit) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage between EX/MEM and MEM/WB. Converts the latched
// load/store/LL/SC controls into a dREN/dWEN request held until dhit,
// stalls upstream meanwhile, and produces the load (or SC) result.
// Ports:
//   CLK, nRST                       : clock, async active-low reset
//   in_valid, in_memRead,
//   in_memWrite, in_ll, in_sc       : EX/MEM controls
//   in_addr, in_store               : effective address, store data
//   dhit, dload                     : dcache completion and read data
//   ccinv, ccsnoopaddr              : coherence snoop invalidation
//   dREN, dWEN, daddr, dstore       : dcache request
//   out_readData                    : load data / SC result for MEM/WB
//   mem_done                        : MEM/WB enable
//   stall                           : freeze the upstream stages
// ---------------------------------------------------------------------------
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  input  logic              in_memRead,
  input  logic              in_memWrite,
  input  logic              in_ll,
  input  logic              in_sc,
  input  logic [WORD_W-1:0] in_addr,
  input  logic [WORD_W-1:0] in_store,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] out_readData,
  output logic              mem_done,
  output logic              stall
);

  memstate_t         state_q, state_n;
  logic              req_read_q, req_write_q, req_ll_q, req_sc_q;
  logic [WORD_W-1:0] read_q;
  logic              memop, sc_ok, sc_fail, busy_hit, link_valid;
  logic              unused_snoop_bits;

  // Snoops are resolved per word, so the byte offset is irrelevant.
  assign unused_snoop_bits = ^ccsnoopaddr[WORDADDR_LSB-1:0];

  assign memop    = in_valid && (in_memRead || in_memWrite);
  assign sc_fail  = memop && in_sc && !sc_ok;
  assign busy_hit = (state_q == BUSY) && dhit;

  // Requests come straight from registers, so an async reset forcing the
  // state to IDLE drops them immediately.
  assign dREN         = (state_q == BUSY) && req_read_q;
  assign dWEN         = (state_q == BUSY) && req_write_q;
  assign out_readData = read_q;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state and handshake outputs; a failed SC skips the bus entirely
  always_comb begin
    state_n  = state_q;
    stall    = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          state_n = sc_fail ? DONE : BUSY;
        end else begin
          mem_done = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dhit) state_n = DONE;
      end
      DONE: begin
        mem_done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture in IDLE and result capture on dhit. Read takes
  // priority over write so the two requests can never both be raised.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      req_ll_q    <= 1'b0;
      req_sc_q    <= 1'b0;
      daddr       <= '0;
      dstore      <= '0;
      read_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sc_fail) begin
            read_q <= '0;
          end else if (memop) begin
            req_read_q  <= in_memRead;
            req_write_q <= in_memWrite && !in_memRead;
            req_ll_q    <= in_ll && in_memRead;
            req_sc_q    <= in_sc && in_memWrite && !in_memRead;
            daddr       <= in_addr;
            dstore      <= in_store;
          end
        end
        BUSY: begin
          if (dhit) begin
            if (req_read_q)    read_q <= dload;
            else if (req_sc_q) read_q <= {{(WORD_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  link_reg #(.WORD_W(WORD_W)) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set_en     (busy_hit && req_ll_q),
    .set_word   (daddr[WORD_W-1:WORDADDR_LSB]),
    .clr_en     (busy_hit && req_sc_q),
    .wr_en      (busy_hit && req_write_q && !req_sc_q),
    .wr_word    (daddr[WORD_W-1:WORDADDR_LSB]),
    .snoop_en   (ccinv),
    .snoop_word (ccsnoopaddr[WORD_W-1:WORDADDR_LSB]),
    .chk_word   (in_addr[WORD_W-1:WORDADDR_LSB]),
    .link_valid (link_valid),
    .sc_ok      (sc_ok)
  );

endmodule
